// File: rtl/jam_rr_scheduler.sv
// Jam-mode round-robin green scheduler.
// Grants green to one jammed road at a time, holds it for a minimum time
// before honouring rotation, and inserts an all-red clearance between
// two different green roads.
module jam_rr_scheduler #(
  parameter int  N_ROADS   = 4,
  parameter int  MIN_GREEN = 8,
  parameter int  CLEAR_CYC = 2,
  localparam int RW        = (N_ROADS > 2) ? $clog2(N_ROADS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jam_op_en,
  input  logic [N_ROADS-1:0] jam_sensor,
  input  logic               jam_start,
  input  logic               jam_rotation,
  output logic [N_ROADS-1:0] allow_jam,
  output logic [RW-1:0]      current_road,
  output logic               clearing,
  output logic               rotate_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GREEN = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  localparam logic [7:0]         MG       = 8'(MIN_GREEN);
  localparam logic [7:0]         CLR_LAST = (CLEAR_CYC > 0) ? 8'(CLEAR_CYC - 1) : 8'd0;
  localparam logic [N_ROADS-1:0] ONE      = {{(N_ROADS-1){1'b0}}, 1'b1};

  // One-hot decode of a road index.
  function automatic logic [N_ROADS-1:0] onehot(input logic [RW-1:0] idx);
    return ONE << idx;
  endfunction

  // Sensor bit at an integer position.
  function automatic logic sensor_at(input logic [N_ROADS-1:0] s, input int idx);
    return |(s & (ONE << idx));
  endfunction

  // Lowest-index jammed road; MSB of the result is the valid flag.
  function automatic logic [RW:0] pick_lowest(input logic [N_ROADS-1:0] s);
    logic [RW:0] r;
    r = {1'b0, {RW{1'b0}}};
    for (int i = N_ROADS - 1; i >= 0; i--) begin
      r = sensor_at(s, i) ? {1'b1, RW'(i)} : r;
    end
    return r;
  endfunction

  // First jammed road after cur, wrapping around and ending on cur itself.
  function automatic logic [RW:0] pick_next(input logic [N_ROADS-1:0] s,
                                            input logic [RW-1:0]      cur);
    logic [RW:0] r;
    int          idx;
    r = {1'b0, {RW{1'b0}}};
    for (int k = N_ROADS; k >= 1; k--) begin
      idx = (int'(cur) + k) % N_ROADS;
      r   = sensor_at(s, idx) ? {1'b1, RW'(idx)} : r;
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [RW-1:0]      cur_q, cur_d;
  logic [7:0]         gcnt_q, gcnt_d;
  logic [7:0]         ccnt_q, ccnt_d;
  logic [RW-1:0]      tgt_q, tgt_d;
  logic               tnone_q, tnone_d;
  logic               ack_q, ack_d;
  logic [N_ROADS-1:0] allow_q, allow_d;
  logic               clearing_q, clearing_d;

  logic [RW:0]        low_s;
  logic [RW:0]        next_s;
  logic [RW:0]        req_s;
  logic               have_req_s;
  logic [RW-1:0]      new_tgt_s;
  logic               new_none_s;

  // Next-state and next-output decision for the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    gcnt_d     = gcnt_q;
    ccnt_d     = ccnt_q;
    tgt_d      = tgt_q;
    tnone_d    = tnone_q;
    ack_d      = 1'b0;
    low_s      = pick_lowest(jam_sensor);
    next_s     = pick_next(jam_sensor, cur_q);
    req_s      = {1'b0, {RW{1'b0}}};
    have_req_s = 1'b0;
    new_tgt_s  = tgt_q;
    new_none_s = tnone_q;

    if (!jam_op_en) begin
      state_d = S_IDLE;
      cur_d   = {RW{1'b0}};
      gcnt_d  = 8'd0;
      ccnt_d  = 8'd0;
      tgt_d   = {RW{1'b0}};
      tnone_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (jam_start && low_s[RW]) begin
            state_d = S_GREEN;
            cur_d   = low_s[RW-1:0];
            gcnt_d  = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_GREEN: begin
          gcnt_d = (gcnt_q != MG) ? gcnt_q + 8'd1 : MG;
          // Start outranks rotation; rotation only counts once the minimum green has elapsed.
          if (jam_start) begin
            have_req_s = 1'b1;
            req_s      = low_s;
          end else if (jam_rotation && (gcnt_q == MG)) begin
            have_req_s = 1'b1;
            req_s      = next_s;
            ack_d      = 1'b1;
          end else begin
            have_req_s = 1'b0;
          end

          if (have_req_s) begin
            if (!req_s[RW]) begin
              if (CLEAR_CYC == 0) begin
                state_d = S_IDLE;
                gcnt_d  = 8'd0;
              end else begin
                state_d = S_CLEAR;
                ccnt_d  = 8'd0;
                tgt_d   = {RW{1'b0}};
                tnone_d = 1'b1;
              end
            end else if (req_s[RW-1:0] == cur_q) begin
              gcnt_d = 8'd0;
            end else if (CLEAR_CYC == 0) begin
              cur_d  = req_s[RW-1:0];
              gcnt_d = 8'd0;
            end else begin
              state_d = S_CLEAR;
              ccnt_d  = 8'd0;
              tgt_d   = req_s[RW-1:0];
              tnone_d = 1'b0;
            end
          end else begin
            state_d = S_GREEN;
          end
        end

        S_CLEAR: begin
          // Only a start request may retarget; the clearance count keeps running.
          if (jam_start) begin
            new_tgt_s  = low_s[RW-1:0];
            new_none_s = ~low_s[RW];
          end else begin
            new_tgt_s  = tgt_q;
            new_none_s = tnone_q;
          end
          tgt_d   = new_tgt_s;
          tnone_d = new_none_s;

          if (ccnt_q == CLR_LAST) begin
            ccnt_d  = 8'd0;
            tnone_d = 1'b1;
            if (new_none_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_GREEN;
              cur_d   = new_tgt_s;
              gcnt_d  = 8'd0;
            end
          end else begin
            ccnt_d = ccnt_q + 8'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
          cur_d   = {RW{1'b0}};
          gcnt_d  = 8'd0;
          ccnt_d  = 8'd0;
          tnone_d = 1'b1;
        end
      endcase
    end

    allow_d    = (state_d == S_GREEN) ? onehot(cur_d) : {N_ROADS{1'b0}};
    clearing_d = (state_d == S_CLEAR);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= {RW{1'b0}};
      gcnt_q     <= 8'd0;
      ccnt_q     <= 8'd0;
      tgt_q      <= {RW{1'b0}};
      tnone_q    <= 1'b1;
      ack_q      <= 1'b0;
      allow_q    <= {N_ROADS{1'b0}};
      clearing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      gcnt_q     <= gcnt_d;
      ccnt_q     <= ccnt_d;
      tgt_q      <= tgt_d;
      tnone_q    <= tnone_d;
      ack_q      <= ack_d;
      allow_q    <= allow_d;
      clearing_q <= clearing_d;
    end
  end

  assign allow_jam    = allow_q;
  assign current_road = cur_q;
  assign clearing     = clearing_q;
  assign rotate_ack   = ack_q;

endmodule
